// File: rtl/ctrl_muestreo_filtro.sv
// Sample-rate sequencer: tick generation, ADC capture, arithmetic-unit handshake, DAC latch.
// Define OFFSET_BIN_EN to remap y(k) from two's complement to offset binary at the DAC register.
module ctrl_muestreo_filtro #(
  parameter int unsigned DW      = 16,
  parameter int unsigned DIV     = 500,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adc_valid,
  input  logic [DW-1:0] adc_dato,
  output logic          datolisto,
  output logic [DW-1:0] xk,
  input  logic          operacionlisto,
  input  logic [DW-1:0] yk,
  output logic [DW-1:0] dac_dato,
  output logic          dac_valid,
  input  logic          clr_err,
  output logic          overrun,
  output logic          timeout_err
);

  localparam int unsigned TickW = $clog2(DIV);
  localparam int unsigned ToW   = $clog2(TIMEOUT);
  localparam logic [TickW-1:0] TickLast = TickW'(DIV - 1);
  // Compared before the increment, so the CALCULO window spans TIMEOUT-1 cycles.
  localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT - 2);

  typedef enum logic [2:0] {
    StEspera  = 3'd0,
    StCaptura = 3'd1,
    StDisparo = 3'd2,
    StCalculo = 3'd3,
    StSalida  = 3'd4
  } state_e;

  state_e           state_q;
  logic [TickW-1:0] tick_q;
  logic [ToW-1:0]   to_cnt_q;
  logic             tick;
  logic             ov_set;
  logic             to_set;

  function automatic logic [DW-1:0] remap(input logic [DW-1:0] v);
`ifdef OFFSET_BIN_EN
    remap = {~v[DW-1], v[DW-2:0]};
`else
    remap = v;
`endif
  endfunction

  assign tick   = (tick_q == TickLast);
  assign ov_set = tick && (state_q != StEspera);
  assign to_set = (state_q == StCalculo) && !operacionlisto && (to_cnt_q == ToLast);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q <= '0;
    end else if (tick) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StEspera;
      to_cnt_q    <= '0;
      xk          <= '0;
      dac_dato    <= '0;
      datolisto   <= 1'b0;
      dac_valid   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      datolisto <= 1'b0;
      dac_valid <= 1'b0;

      // Sticky flags: a set condition overrides a simultaneous clear.
      if (ov_set) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
      if (to_set) begin
        timeout_err <= 1'b1;
      end else if (clr_err) begin
        timeout_err <= 1'b0;
      end

      case (state_q)
        StEspera: begin
          if (tick) state_q <= StCaptura;
        end
        StCaptura: begin
          if (adc_valid) begin
            xk        <= adc_dato;
            datolisto <= 1'b1;
            state_q   <= StDisparo;
          end
        end
        StDisparo: begin
          to_cnt_q <= '0;
          state_q  <= StCalculo;
        end
        StCalculo: begin
          if (operacionlisto) begin
            dac_dato  <= remap(yk);
            dac_valid <= 1'b1;
            state_q   <= StSalida;
          end else if (to_cnt_q == ToLast) begin
            state_q <= StEspera;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        StSalida: begin
          state_q <= StEspera;
        end
        default: begin
          state_q <= StEspera;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_muestreo_filtro.sv
// Bench for ctrl_muestreo_filtro: deadline-based transaction model checked every cycle,
// plus directed literal checks of latency, timeout, overrun, reset abort and DAC mapping.
module tb_ctrl_muestreo_filtro;

  localparam int unsigned DW      = 16;
  localparam int unsigned DIV     = 20;
  localparam int unsigned TIMEOUT = 16;
  localparam int          Never   = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] adc_dato = '0;
  logic          operacionlisto = 1'b0;
  logic [DW-1:0] yk = '0;
  logic          clr_err = 1'b0;
  logic          datolisto, dac_valid, overrun, timeout_err;
  logic [DW-1:0] xk, dac_dato;

  int tests = 0;
  int fails = 0;

  ctrl_muestreo_filtro #(
    .DW(DW),
    .DIV(DIV),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .adc_valid(adc_valid),
    .adc_dato(adc_dato),
    .datolisto(datolisto),
    .xk(xk),
    .operacionlisto(operacionlisto),
    .yk(yk),
    .dac_dato(dac_dato),
    .dac_valid(dac_valid),
    .clr_err(clr_err),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] dac_map(input logic [DW-1:0] v);
`ifdef OFFSET_BIN_EN
    dac_map = v ^ 16'h8000;
`else
    dac_map = v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      if (fails >= 50) begin
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  endtask

  // Reference model: a transaction opens on an idle tick, fires one cycle after the ADC word,
  // and has a completion window of fire+1 .. fire+TIMEOUT-1.
  int n, cyc;
  bit m_wait;
  int m_fire, m_free;
  bit m_idle, m_tick, set_ov, set_to;
  logic [DW-1:0] e_xk, e_dac;
  bit e_dl, e_dv, e_ov, e_to;

  int dl_count = 0, dv_count = 0, to_count = 0;
  int dl_cyc, dv_cyc, to_cyc, first_dl_n;
  bit prev_to;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      check("rst_datolisto", datolisto, 0);
      check("rst_dac_valid", dac_valid, 0);
      check("rst_xk", xk, 0);
      check("rst_dac_dato", dac_dato, 0);
      check("rst_overrun", overrun, 0);
      check("rst_timeout_err", timeout_err, 0);
      n = 0; m_wait = 0; m_fire = -1; m_free = 0;
      e_xk = '0; e_dac = '0; e_dl = 0; e_dv = 0; e_ov = 0; e_to = 0;
      prev_to = 0; first_dl_n = -1;
    end else begin
      check("datolisto", datolisto, e_dl);
      check("dac_valid", dac_valid, e_dv);
      check("xk", xk, e_xk);
      check("dac_dato", dac_dato, e_dac);
      check("overrun", overrun, e_ov);
      check("timeout_err", timeout_err, e_to);
      if (datolisto) begin
        dl_count++; dl_cyc = cyc;
        if (first_dl_n < 0) first_dl_n = n;
      end
      if (dac_valid) begin dv_count++; dv_cyc = cyc; end
      if (timeout_err && !prev_to) begin to_count++; to_cyc = cyc; end
      prev_to = timeout_err;

      m_idle = !m_wait && (n >= m_free);
      m_tick = (n % DIV) == (DIV - 1);
      e_dl = 0; e_dv = 0; set_ov = 0; set_to = 0;
      if (m_wait && adc_valid) begin
        e_xk = adc_dato; e_dl = 1; m_fire = n + 1; m_wait = 0; m_free = Never;
      end else if (m_fire >= 0 && n > m_fire && n <= m_fire + TIMEOUT - 1) begin
        if (operacionlisto) begin
          e_dac = dac_map(yk); e_dv = 1; m_free = n + 2; m_fire = -1;
        end else if (n == m_fire + TIMEOUT - 1) begin
          set_to = 1; m_free = n + 1; m_fire = -1;
        end
      end
      if (m_tick) begin
        if (m_idle) m_wait = 1;
        else set_ov = 1;
      end
      e_ov = set_ov | (e_ov & !clr_err);
      e_to = set_to | (e_to & !clr_err);
      n++;
    end
  end

  // Arithmetic-unit stand-in: answers resp cycles after the cycle following datolisto.
  int resp = 5;
  bit resp_rand = 0;
  bit stray = 0;
  logic [DW-1:0] yk_val = '0;
  int pend = 0;
  int r;

  initial forever begin
    @(posedge clk);
    #1;
    operacionlisto = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin operacionlisto = 1'b1; yk = yk_val; end
    end
    if (datolisto) begin
      r = resp_rand ? int'($urandom_range(0, 16)) : resp;
      if (r >= 0) pend = r + 1;
    end
    if (stray && $urandom_range(0, 15) == 0) begin
      operacionlisto = 1'b1; yk = DW'($urandom);
    end
  end

  task automatic cycles(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // which: 0 = datolisto, 1 = dac_valid, 2 = timeout_err rise
  task automatic wait_ev(input string name, input int which, input int lim);
    int c0;
    c0 = (which == 0) ? dl_count : (which == 1) ? dv_count : to_count;
    for (int i = 0; i < lim; i++) begin
      cycles(1);
      if (((which == 0) ? dl_count : (which == 1) ? dv_count : to_count) != c0) return;
    end
    tests++; fails++;
    $display("FAIL %s: event not seen within %0d cycles", name, lim);
  endtask

  int dv0;

  initial begin
    // Reset held for 3 cycles, then released just after an edge.
    cycles(3);
    adc_valid = 1'b1; adc_dato = 16'h1234; resp = 5; yk_val = 16'h0F00;
    reset = 1'b1;

    wait_ev("first_datolisto", 0, 3 * DIV);
    check("first_datolisto_n", first_dl_n, DIV + 1);
    wait_ev("first_dac_valid", 1, 40);
    check("latency", dv_cyc - dl_cyc, 7);
`ifdef OFFSET_BIN_EN
    check("dac_0f00", dac_dato, 16'h8F00);
`else
    check("dac_0f00", dac_dato, 16'h0F00);
`endif
    check("xk_1234", xk, 16'h1234);
    check("no_overrun", overrun, 0);

    // No answer: timeout.
    resp = -1; dv0 = dv_count;
    wait_ev("to_datolisto", 0, 3 * DIV);
    wait_ev("timeout_rise", 2, 40);
    check("timeout_delay", to_cyc - dl_cyc, 16);
    check("timeout_no_dv", dv_count, dv0);
    check("timeout_err_set", timeout_err, 1);
    resp = 5;
    wait_ev("after_timeout_datolisto", 0, 3 * DIV);
    wait_ev("after_timeout_dv", 1, 40);

    // ADC stall across two ticks.
    adc_valid = 1'b0;
    cycles(2 * DIV);
    check("overrun_set", overrun, 1);
    adc_valid = 1'b1;
    cycles(1);
    check("datolisto_after_adc", datolisto, 1);
    wait_ev("stall_dv", 1, 40);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    check("overrun_cleared", overrun, 0);
    check("timeout_cleared", timeout_err, 0);

    // Reset during CALCULO; the late answer must be ignored.
    resp = 8;
    wait_ev("rst_datolisto_wait", 0, 3 * DIV);
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    dv0 = dv_count;
    cycles(15);
    check("late_op_no_dv", dv_count, dv0);
    resp = 5;

    // DAC mapping boundaries.
    yk_val = 16'h8000;
    wait_ev("map_8000", 1, 4 * DIV);
`ifdef OFFSET_BIN_EN
    check("dac_8000", dac_dato, 16'h0000);
`else
    check("dac_8000", dac_dato, 16'h8000);
`endif
    yk_val = 16'h7FFF;
    wait_ev("map_7fff", 1, 4 * DIV);
`ifdef OFFSET_BIN_EN
    check("dac_7fff", dac_dato, 16'hFFFF);
`else
    check("dac_7fff", dac_dato, 16'h7FFF);
`endif

    // Randomized traffic, varying ADC availability per chunk.
    resp_rand = 1; stray = 1;
    for (int chunk = 0; chunk < 20; chunk++) begin
      int p;
      p = $urandom_range(1, 8);
      for (int i = 0; i < 150; i++) begin
        adc_valid = ($urandom_range(0, 7) < p);
        adc_dato  = DW'($urandom);
        yk_val    = DW'($urandom);
        clr_err   = ($urandom_range(0, 9) == 0);
        cycles(1);
      end
    end
    clr_err = 1'b0; stray = 0; resp_rand = 0;
    cycles(3 * DIV);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
